// File: rtl/counter_updn_mod.sv
// Up/down counter with synchronous clear/load, an upper limit of MAX_VALUE,
// wrap or saturate at the limits, and a registered one-cycle rollover flag.
module counter_updn_mod #(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    MAX_VALUE = {WIDTH{1'b1}},
  parameter bit                  SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             at_zero,
  output logic             at_max,
  output logic             rollover
);

  logic [WIDTH-1:0] r_counter;
  logic             r_rollover;

  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextRoll;
  logic             w_atZero;
  logic             w_atMax;
  logic [WIDTH-1:0] w_loadClamped;

  assign w_atZero      = (r_counter == '0);
  assign w_atMax       = (r_counter == MAX_VALUE);
  assign w_loadClamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

  // Priority: clear, load, count step, hold. A step that meets a limit
  // raises rollover whether it wraps or is blocked by saturation.
  always_comb begin
    w_nextCount = r_counter;
    w_nextRoll  = 1'b0;
    if (clear) begin
      w_nextCount = '0;
    end else if (load) begin
      w_nextCount = w_loadClamped;
    end else if (enable) begin
      if (up_down) begin
        if (w_atMax) begin
          w_nextRoll  = 1'b1;
          w_nextCount = SATURATE ? MAX_VALUE : '0;
        end else begin
          w_nextCount = r_counter + 1'b1;
        end
      end else begin
        if (w_atZero) begin
          w_nextRoll  = 1'b1;
          w_nextCount = SATURATE ? '0 : MAX_VALUE;
        end else begin
          w_nextCount = r_counter - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_counter  <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_counter  <= w_nextCount;
      r_rollover <= w_nextRoll;
    end
  end

  assign counter  = r_counter;
  assign rollover = r_rollover;
  assign at_zero  = w_atZero;
  assign at_max   = w_atMax;

  // The count must never leave 0..MAX_VALUE.
  assert property (@(posedge clock) disable iff (!reset) r_counter <= MAX_VALUE);

endmodule

// File: tb/tb_counter_updn_mod.sv
// Randomized and directed checks of counter_updn_mod against a behavioural
// model; three instances cover wrap, saturate and the default 8-bit range.
module tb_counter_updn_mod;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       enable = 1'b0;
  logic       upDown = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] loadValue4 = '0;
  logic [7:0] loadValue8 = '0;

  logic [3:0] cnt0, cnt1;
  logic [7:0] cnt2;
  logic       zero0, zero1, zero2, max0, max1, max2, roll0, roll1, roll2;

  int nComp = 0;
  int nFail = 0;
  int mCnt[3];
  int mRoll[3];
  int mMax[3] = '{9, 9, 255};
  int mSat[3] = '{0, 1, 0};

  always #5 clock = ~clock;

  counter_updn_mod #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0)) dutWrap (
    .clock(clock), .reset(resetN), .enable(enable), .up_down(upDown),
    .clear(clear), .load(load), .load_value(loadValue4),
    .counter(cnt0), .at_zero(zero0), .at_max(max0), .rollover(roll0));

  counter_updn_mod #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b1)) dutSat (
    .clock(clock), .reset(resetN), .enable(enable), .up_down(upDown),
    .clear(clear), .load(load), .load_value(loadValue4),
    .counter(cnt1), .at_zero(zero1), .at_max(max1), .rollover(roll1));

  counter_updn_mod dutDefault (
    .clock(clock), .reset(resetN), .enable(enable), .up_down(upDown),
    .clear(clear), .load(load), .load_value(loadValue8),
    .counter(cnt2), .at_zero(zero2), .at_max(max2), .rollover(roll2));

  function automatic int dutCnt(int i);
    return (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
  endfunction
  function automatic int dutZero(int i);
    return (i == 0) ? int'(zero0) : (i == 1) ? int'(zero1) : int'(zero2);
  endfunction
  function automatic int dutMax(int i);
    return (i == 0) ? int'(max0) : (i == 1) ? int'(max1) : int'(max2);
  endfunction
  function automatic int dutRoll(int i);
    return (i == 0) ? int'(roll0) : (i == 1) ? int'(roll1) : int'(roll2);
  endfunction

  // Advance the behavioural model from the current inputs, then take one edge.
  task automatic doEdge();
    for (int i = 0; i < 3; i++) begin
      int lv;
      bit limitHit;
      lv = (i == 2) ? int'(loadValue8) : int'(loadValue4);
      if (!resetN) begin
        mCnt[i] = 0; mRoll[i] = 0;
      end else if (clear) begin
        mCnt[i] = 0; mRoll[i] = 0;
      end else if (load) begin
        mCnt[i] = (lv > mMax[i]) ? mMax[i] : lv; mRoll[i] = 0;
      end else if (enable) begin
        limitHit = upDown ? (mCnt[i] == mMax[i]) : (mCnt[i] == 0);
        mRoll[i] = limitHit ? 1 : 0;
        if (!(limitHit && mSat[i] != 0))
          mCnt[i] = upDown ? (mCnt[i] + 1) % (mMax[i] + 1)
                           : (mCnt[i] + mMax[i]) % (mMax[i] + 1);
      end else begin
        mRoll[i] = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mCnt[i] = 0; mRoll[i] = 0;
    end
  endtask

  task automatic test_reset();
    modelReset();
    enable = 1'b1; upDown = 1'b1; load = 1'b1; loadValue4 = 4'd5; loadValue8 = 8'd5;
    doEdge();
    doEdge();
    nComp++; if (cnt0 !== 4'd0) begin nFail++; $display("[TB] FAIL reset cnt0 got %0d want 0", cnt0); end
    nComp++; if (cnt2 !== 8'd0) begin nFail++; $display("[TB] FAIL reset cnt2 got %0d want 0", cnt2); end
    nComp++; if (zero0 !== 1'b1) begin nFail++; $display("[TB] FAIL reset atZero got %b want 1", zero0); end
    nComp++; if (max0 !== 1'b0) begin nFail++; $display("[TB] FAIL reset atMax got %b want 0", max0); end
    nComp++; if (roll1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset rollover got %b want 0", roll1); end
    resetN = 1'b1; load = 1'b0; enable = 1'b0;
    doEdge();
    nComp++; if (cnt0 !== 4'd0) begin nFail++; $display("[TB] FAIL resetHold cnt0 got %0d want 0", cnt0); end
  endtask

  task automatic test_wrap_up();
    load = 1'b1; loadValue4 = 4'd9; loadValue8 = 8'd9;
    doEdge();
    load = 1'b0; enable = 1'b1; upDown = 1'b1;
    doEdge();
    nComp++; if (cnt0 !== 4'd0) begin nFail++; $display("[TB] FAIL wrapUp cnt got %0d want 0", cnt0); end
    nComp++; if (roll0 !== 1'b1) begin nFail++; $display("[TB] FAIL wrapUp rollover got %b want 1", roll0); end
    nComp++; if (zero0 !== 1'b1) begin nFail++; $display("[TB] FAIL wrapUp atZero got %b want 1", zero0); end
    enable = 1'b0;
    doEdge();
    nComp++; if (roll0 !== 1'b0) begin nFail++; $display("[TB] FAIL wrapUpPulse rollover got %b want 0", roll0); end
  endtask

  task automatic test_wrap_down();
    enable = 1'b1; upDown = 1'b0;
    doEdge();
    nComp++; if (cnt0 !== 4'd9) begin nFail++; $display("[TB] FAIL wrapDown cnt got %0d want 9", cnt0); end
    nComp++; if (max0 !== 1'b1) begin nFail++; $display("[TB] FAIL wrapDown atMax got %b want 1", max0); end
    nComp++; if (roll0 !== 1'b1) begin nFail++; $display("[TB] FAIL wrapDown rollover got %b want 1", roll0); end
    enable = 1'b0;
    doEdge();
  endtask

  task automatic test_saturate();
    load = 1'b1; loadValue4 = 4'd9; loadValue8 = 8'd9;
    doEdge();
    load = 1'b0; enable = 1'b1; upDown = 1'b1;
    for (int k = 0; k < 3; k++) begin
      doEdge();
      nComp++; if (cnt1 !== 4'd9) begin nFail++; $display("[TB] FAIL satUp%0d cnt got %0d want 9", k, cnt1); end
      nComp++; if (roll1 !== 1'b1) begin nFail++; $display("[TB] FAIL satUp%0d rollover got %b want 1", k, roll1); end
    end
    enable = 1'b0;
    doEdge();
    nComp++; if (roll1 !== 1'b0) begin nFail++; $display("[TB] FAIL satIdle rollover got %b want 0", roll1); end
    clear = 1'b1;
    doEdge();
    clear = 1'b0; enable = 1'b1; upDown = 1'b0;
    doEdge();
    nComp++; if (cnt1 !== 4'd0) begin nFail++; $display("[TB] FAIL satDown cnt got %0d want 0", cnt1); end
    nComp++; if (roll1 !== 1'b1) begin nFail++; $display("[TB] FAIL satDown rollover got %b want 1", roll1); end
    enable = 1'b0;
  endtask

  task automatic test_priority_clamp();
    clear = 1'b1; load = 1'b1; loadValue4 = 4'd5; loadValue8 = 8'd5; enable = 1'b1; upDown = 1'b1;
    doEdge();
    nComp++; if (cnt0 !== 4'd0) begin nFail++; $display("[TB] FAIL clearWins cnt got %0d want 0", cnt0); end
    clear = 1'b0; loadValue4 = 4'd15; loadValue8 = 8'd15; enable = 1'b0;
    doEdge();
    nComp++; if (cnt0 !== 4'd9) begin nFail++; $display("[TB] FAIL clamp cnt got %0d want 9", cnt0); end
    nComp++; if (roll0 !== 1'b0) begin nFail++; $display("[TB] FAIL clamp rollover got %b want 0", roll0); end
    nComp++; if (cnt2 !== 8'd15) begin nFail++; $display("[TB] FAIL load8 cnt got %0d want 15", cnt2); end
    loadValue4 = 4'd9; enable = 1'b1; upDown = 1'b1;
    doEdge();
    nComp++; if (roll0 !== 1'b0) begin nFail++; $display("[TB] FAIL loadAtLimit rollover got %b want 0", roll0); end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; loadValue4 = 4'd3; loadValue8 = 8'd3;
    doEdge();
    load = 1'b0; enable = 1'b1;
    upDown = 1'b1; doEdge();
    nComp++; if (cnt0 !== 4'd4) begin nFail++; $display("[TB] FAIL b2bUp cnt got %0d want 4", cnt0); end
    upDown = 1'b0; doEdge();
    nComp++; if (cnt0 !== 4'd3) begin nFail++; $display("[TB] FAIL b2bDown cnt got %0d want 3", cnt0); end
    upDown = 1'b1; doEdge();
    nComp++; if (cnt0 !== 4'd4) begin nFail++; $display("[TB] FAIL b2bUp2 cnt got %0d want 4", cnt0); end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; loadValue4 = 4'd6; loadValue8 = 8'd6;
    doEdge();
    load = 1'b0;
    nComp++; if (cnt0 !== 4'd6) begin nFail++; $display("[TB] FAIL preReset cnt got %0d want 6", cnt0); end
    #2 resetN = 1'b0; modelReset();
    #1;
    nComp++; if (cnt0 !== 4'd0) begin nFail++; $display("[TB] FAIL asyncReset cnt got %0d want 0", cnt0); end
    #1 resetN = 1'b1;
    enable = 1'b1; upDown = 1'b1;
    doEdge();
    nComp++; if (cnt0 !== 4'd1) begin nFail++; $display("[TB] FAIL firstEdge cnt got %0d want 1", cnt0); end
    enable = 1'b0; load = 1'b1; loadValue4 = 4'd9; loadValue8 = 8'd9;
    doEdge();
    load = 1'b0; enable = 1'b1;
    doEdge();
    nComp++; if (roll0 !== 1'b1) begin nFail++; $display("[TB] FAIL preResetRoll got %b want 1", roll0); end
    #2 resetN = 1'b0; modelReset();
    #1;
    nComp++; if (roll0 !== 1'b0) begin nFail++; $display("[TB] FAIL resetDropsRoll got %b want 0", roll0); end
    #1 resetN = 1'b1;
    enable = 1'b0;
  endtask

  task automatic test_full_range();
    int pulses;
    pulses = 0;
    clear = 1'b1;
    doEdge();
    clear = 1'b0; enable = 1'b1; upDown = 1'b1;
    for (int k = 0; k < 256; k++) begin
      doEdge();
      if (roll2 === 1'b1) pulses++;
    end
    nComp++; if (cnt2 !== 8'd0) begin nFail++; $display("[TB] FAIL fullRange cnt got %0d want 0", cnt2); end
    nComp++; if (pulses != 1) begin nFail++; $display("[TB] FAIL fullRange pulses got %0d want 1", pulses); end
    enable = 1'b0;
    doEdge();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      clear      = ($urandom_range(15) == 0);
      load       = ($urandom_range(7) == 0);
      enable     = ($urandom_range(3) != 0);
      upDown     = $urandom_range(1);
      loadValue4 = 4'($urandom_range(15));
      loadValue8 = 8'($urandom_range(255));
      doEdge();
      for (int i = 0; i < 3; i++) begin
        nComp++; if (dutCnt(i) != mCnt[i]) begin nFail++; $display("[TB] FAIL rand%0d cnt inst%0d got %0d want %0d", k, i, dutCnt(i), mCnt[i]); end
        nComp++; if (dutRoll(i) != mRoll[i]) begin nFail++; $display("[TB] FAIL rand%0d rollover inst%0d got %0d want %0d", k, i, dutRoll(i), mRoll[i]); end
        nComp++; if (dutZero(i) != int'(mCnt[i] == 0)) begin nFail++; $display("[TB] FAIL rand%0d atZero inst%0d got %0d want %0d", k, i, dutZero(i), int'(mCnt[i] == 0)); end
        nComp++; if (dutMax(i) != int'(mCnt[i] == mMax[i])) begin nFail++; $display("[TB] FAIL rand%0d atMax inst%0d got %0d want %0d", k, i, dutMax(i), int'(mCnt[i] == mMax[i])); end
      end
    end
    clear = 1'b0; load = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority_clamp();
    test_back_to_back();
    test_async_reset();
    test_full_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
